// File: rtl/packet_injector.sv
// Host-side ingress loader: the host pushes bytes into three lane FIFOs over an
// Avalon-MM style slave port; each lane drains into a valid/ready output stage.
module packet_injector #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic       read,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic [7:0] out_data1,
    output logic [7:0] out_data2,
    output logic [7:0] out_data3,
    output logic       out_valid1,
    output logic       out_valid2,
    output logic       out_valid3,
    input  logic       out_ready1,
    input  logic       out_ready2,
    input  logic       out_ready3
);

    localparam int NL = 3;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, HOLD} lane_state_e;

    logic [7:0]    mem_q   [NL][DEPTH];
    logic [PW-1:0] wptr_q  [NL];
    logic [PW-1:0] wptr_d  [NL];
    logic [PW-1:0] rptr_q  [NL];
    logic [PW-1:0] rptr_d  [NL];
    logic [CW-1:0] cnt_q   [NL];
    logic [CW-1:0] cnt_d   [NL];
    lane_state_e   state_q [NL];
    lane_state_e   state_d [NL];
    logic [7:0]    odata_q [NL];
    logic [7:0]    odata_d [NL];
    logic [2:0]    en_q, en_d;
    logic [2:0]    ovf_q, ovf_d;
    logic [7:0]    readdata_q, readdata_d;

    logic          wr, rd, flush;
    logic [NL-1:0] ready, push, push_ok, pop, full, nonempty, lane_empty;

    assign wr    = chipselect && write;
    assign rd    = chipselect && read;
    assign flush = wr && (address == 3'd3) && writedata[7];
    assign ready = {out_ready3, out_ready2, out_ready1};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        en_d = en_q;
        if (wr && address == 3'd3) en_d = writedata[2:0];

        ovf_d = ovf_q;
        if (wr && address == 3'd5) ovf_d = ovf_q & ~writedata[2:0];

        for (int i = 0; i < NL; i++) begin
            full[i]     = (cnt_q[i] == FULL_CNT);
            nonempty[i] = (cnt_q[i] != '0);
            push[i]     = wr && (address == 3'(i));
            push_ok[i]  = push[i] && !full[i] && !flush;
            // A full-FIFO push is dropped even if a pop frees a slot this cycle; set beats W1C.
            if (push[i] && full[i]) ovf_d[i] = 1'b1;

            pop[i]     = 1'b0;
            state_d[i] = state_q[i];
            odata_d[i] = odata_q[i];
            case (state_q[i])
                IDLE: if (en_q[i] && nonempty[i]) pop[i] = 1'b1;
                HOLD: if (ready[i]) begin
                    if (en_q[i] && nonempty[i]) pop[i] = 1'b1;
                    else                        state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
            if (pop[i]) begin
                odata_d[i] = mem_q[i][rptr_q[i]];
                state_d[i] = HOLD;
            end

            wptr_d[i] = wptr_q[i] + PW'(push_ok[i]);
            rptr_d[i] = rptr_q[i] + PW'(pop[i]);
            cnt_d[i]  = cnt_q[i] + CW'(push_ok[i]) - CW'(pop[i]);

            if (flush) begin
                pop[i]     = 1'b0;
                wptr_d[i]  = '0;
                rptr_d[i]  = '0;
                cnt_d[i]   = '0;
                state_d[i] = IDLE;
                odata_d[i] = '0;
            end

            lane_empty[i] = !nonempty[i] && (state_q[i] == IDLE);
        end

        readdata_d = readdata_q;
        if (rd) begin
            case (address)
                3'd0:    readdata_d = 8'(cnt_q[0]);
                3'd1:    readdata_d = 8'(cnt_q[1]);
                3'd2:    readdata_d = 8'(cnt_q[2]);
                3'd3:    readdata_d = {5'b0, en_q};
                3'd4:    readdata_d = {2'b00, ovf_q, lane_empty};
                default: readdata_d = 8'd252;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= '0;
            ovf_q      <= '0;
            readdata_q <= '0;
            for (int i = 0; i < NL; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
                odata_q[i] <= '0;
            end
        end else begin
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < NL; i++) begin
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
                odata_q[i] <= odata_d[i];
            end
        end
    end

    // NOTE: FIFO storage is not reset; occupancy gates every read so stale entries are never seen.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (push_ok[i]) mem_q[i][wptr_q[i]] <= writedata;
        end
    end

    assign readdata   = readdata_q;
    assign out_data1  = odata_q[0];
    assign out_data2  = odata_q[1];
    assign out_data3  = odata_q[2];
    assign out_valid1 = (state_q[0] == HOLD);
    assign out_valid2 = (state_q[1] == HOLD);
    assign out_valid3 = (state_q[2] == HOLD);

endmodule

// File: doc/packet_injector.md
Name: packet_injector

Overview:
- Host-side ingress loader for the switch: the write-direction counterpart of the result capture buffer.
- The host pushes packet bytes over an Avalon-MM style slave port into three per-lane FIFOs.
- The block streams each lane's bytes into the corresponding switch input port using a valid/ready handshake.
- Status and occupancy are readable over the same slave port.

Parameters:
- DEPTH, 16, entries per lane FIFO; power of two, 2..128.
- CW, $clog2(DEPTH)+1, occupancy counter width; always ≤ 8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- chipselect  input  1  slave select.
- write  input  1  write strobe, qualified by chipselect.
- read  input  1  read strobe, qualified by chipselect.
- address  input  3  register select.
- writedata  input  8  write payload.
- readdata  output  8  registered read data.
- out_data1, out_data2, out_data3  output  8 each  lane byte to switch input 1..3.
- out_valid1, out_valid2, out_valid3  output  1 each  lane byte valid.
- out_ready1, out_ready2, out_ready3  input  1 each  switch input accepts byte.

Behaviour:
- Reset: all FIFOs empty; enables=000; overflow=000; out_validN=0; out_dataN=0; readdata=0. A mid-stream reset discards everything, and out_valid drops on the next edge.
- Register map, writes (chipselect&&write):
  - 0/1/2: push writedata into lane 1/2/3 FIFO.
  - 3: CTRL. Bits[2:0] are the lane enables. Bit7=1 flushes all FIFOs and output registers for one cycle; enables take writedata[2:0] in the same cycle.
  - 5: write-1-to-clear of overflow bits[2:0].
  - Other addresses: ignored.
- Register map, reads (chipselect&&read), readdata updated on the next edge, one-cycle latency:
  - 0/1/2: zero-extended FIFO occupancy of lane 1/2/3; the output register is excluded.
  - 3: {5'b0, enables}.
  - 4: STATUS = {1'b0, 1'b0, overflow[2:0], empty[2:0]}. Here emptyN = FIFO empty and out_validN=0.
  - 5..7: 8'd252.
  - When no read is active, readdata holds its last value. Reads have no side effects.
- Push rules:
  - A push to a full FIFO (occupancy==DEPTH) is dropped and sets the sticky overflowN bit. This applies even if a pop happens in the same cycle.
  - A push to an empty lane is accepted regardless of the enable bit.
  - Simultaneous push and W1C on the same lane: set wins.
- Pointers: read and write pointers wrap modulo DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.
- Lane output stage, per lane, two states:
  - IDLE (out_valid=0). Go to HOLD when enabled && FIFO non-empty: pop the head into out_data and set out_valid.
  - HOLD (out_valid=1). out_data is stable while out_ready=0.
  - On out_valid&&out_ready:
    - If enabled && FIFO non-empty: pop the next byte in the same cycle and stay in HOLD. This gives one byte per cycle with ready held high.
    - Otherwise: go to IDLE.
- Latency: a byte pushed on edge N into an empty, enabled lane sets out_valid after edge N+1.
- Disabling a lane in HOLD: the held byte stays valid until accepted and is never retracted. No further pops occur.
- Flush: clears the FIFOs, occupancy and out_valid on the next edge, overriding any same-cycle push and handshake. Overflow bits are not cleared.
- Lane independence: lanes operate independently. A stall on one lane never affects another.

Test Plan:
- Reset, enable=111, push 0x11,0x22,0x33 to lane 1, out_ready1=1 -> out_data1 is 0x11,0x22,0x33 on consecutive cycles; first out_valid1 2 edges after the first push. STATUS read afterwards -> 8'h07.
- Enable=000, push 16 bytes to lane 2, push a 17th -> read addr 1 returns 16 and STATUS bit4=1. Write 5 with 0x02 -> bit4 clears. out_valid2 stays 0 throughout.
- Lane 3 enabled, out_ready3=0 with 0xA5 held -> out_data3 stays 0xA5 for 10 cycles. Disable lane 3, then assert ready -> 0xA5 accepted once, out_valid3 then 0, remaining bytes stay in the FIFO.
- Fill lane 1 to full, then push and pop in the same cycle -> push dropped, overflow1 set, occupancy 15.
- Mid-stream write CTRL=0x87 -> next edge: all out_valid=0, occupancies 0, overflow bits preserved, enables=111.
- Read addr 6 -> 252. Read addr 2 with 5 queued -> 5 one cycle later. No read -> readdata unchanged.
